instr_buffer: RTL and testbench
===============================

INSTR_BUFFER -- requirements
Module: instr_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of buffered instruction entries (power of two, minimum 2).
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h0000_0013, driven on instr_o when the buffer is empty.
REQ-003 The block SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit, the reset, asynchronous and active-high.
REQ-005 The block SHALL have port flush_i, input, 1 bit, the redirect flush from the PC/redirect logic.
REQ-006 The block SHALL have port ic_rsp_valid_i, input, 1 bit, meaning the fetch stage presents an instruction response.
REQ-007 The block SHALL have port ic_rsp_ready_o, output, 1 bit, meaning the buffer accepts a response this cycle.
REQ-008 The block SHALL have port ic_rsp_data_i, input, 32 bits, the fetched instruction word.
REQ-009 The block SHALL have port ic_rsp_pc_i, input, 32 bits, the PC of the fetched instruction.
REQ-010 The block SHALL have port ic_rsp_epoch_i, input, 1 bit, the epoch tag the fetch stage attached when the request was issued.
REQ-011 The block SHALL have port epoch_o, output, 1 bit, the current fetch epoch, used by fetch to tag new requests.
REQ-012 The block SHALL have port instr_valid_o, output, 1 bit, meaning decode is offered a valid instruction.
REQ-013 The block SHALL have port instr_ready_i, input, 1 bit, meaning decode consumes the offered instruction.
REQ-014 The block SHALL have port instr_o, output, 32 bits, the head instruction word.
REQ-015 The block SHALL have port pc_o, output, 32 bits, the head instruction PC.
REQ-016 The block SHALL have port count_o, output, clog2(DEPTH)+1 bits, the number of valid entries.
REQ-017 The block SHALL have port stale_drop_o, output, 1 bit, a one-cycle pulse when a stale-epoch response is discarded.

Function
REQ-018 Storage SHALL be a circular FIFO of {instr, pc}, with read and write pointers of clog2(DEPTH) bits plus a wrap bit; full when the indices are equal and the wrap bits differ, empty when the pointers are equal.
REQ-019 ic_rsp_ready_o SHALL equal (count_o < DEPTH) AND NOT flush_i, and SHALL NOT depend on ic_rsp_valid_i.
REQ-020 Accept: ic_rsp_valid_i AND ic_rsp_ready_o AND (ic_rsp_epoch_i == epoch_o) SHALL write the entry at the write pointer and increment the write pointer modulo 2*DEPTH.
REQ-021 Stale drop: a handshake with ic_rsp_epoch_i != epoch_o SHALL not write an entry and SHALL pulse stale_drop_o in the following cycle.
REQ-022 instr_valid_o SHALL equal (count_o != 0) AND NOT flush_i.
REQ-023 instr_o and pc_o SHALL show the head entry when non-empty; otherwise they SHALL be NOP_INSTR and 32'h0.
REQ-024 Dequeue: instr_valid_o AND instr_ready_i SHALL advance the read pointer by one.
REQ-025 Latency: an accepted response SHALL appear on instr_valid_o in the next cycle; there is no same-cycle bypass when empty.
REQ-026 Simultaneous enqueue and dequeue SHALL leave count_o unchanged; because ready is low when full, no enqueue occurs when count_o == DEPTH, even with a dequeue in the same cycle.
REQ-027 Flush: when flush_i is high, the next cycle SHALL show count_o = 0, both pointers at 0 and epoch_o inverted, and no enqueue or dequeue occurs in the flush cycle.
REQ-028 Consecutive flush cycles SHALL toggle epoch_o once per cycle.
REQ-029 Pointer wrap SHALL be seamless: the ordering of entries SHALL be preserved across the DEPTH boundary.

Reset
REQ-030 rst_i high SHALL immediately force pointers = 0, count_o = 0, epoch_o = 0, stale_drop_o = 0, instr_valid_o = 0, instr_o = NOP_INSTR and pc_o = 0, irrespective of clk_i.
REQ-031 Reset asserted mid-operation SHALL discard all entries, and no handshake SHALL complete while rst_i is high; ic_rsp_ready_o SHALL be 0 during reset.

Verification
REQ-032 Reset, then push 0x00000093 @ PC 0x100 with epoch 0 -> next cycle instr_valid_o = 1, instr_o = 0x00000093, pc_o = 0x100, count_o = 1.
REQ-033 Push 4 entries with instr_ready_i = 0 -> count_o = 4 and ic_rsp_ready_o = 0; a fifth valid response is held and not lost; after one dequeue it is accepted.
REQ-034 Hold both sides active for 10 cycles with PCs 0x0..0x24 -> count_o stays constant and decode receives the PCs in order across the pointer wrap.
REQ-035 With 3 entries buffered, pulse flush_i -> next cycle count_o = 0, instr_valid_o = 0, epoch_o = 1; a following response with epoch 0 is dropped with a stale_drop_o pulse; a response with epoch 1 is accepted.
REQ-036 Assert rst_i asynchronously between clock edges with 2 entries buffered -> instr_valid_o falls before the next edge and instr_o = 0x00000013.

Source files
------------

// File: rtl/instr_buffer_if.sv
// rtl/instr_buffer_if.sv - fetch-response, decode and control signals of the instruction buffer
interface instr_buffer_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          flush_i;
   logic          ic_rsp_valid_i;
   logic          ic_rsp_ready_o;
   logic [31:0]   ic_rsp_data_i;
   logic [31:0]   ic_rsp_pc_i;
   logic          ic_rsp_epoch_i;
   logic          epoch_o;
   logic          instr_valid_o;
   logic          instr_ready_i;
   logic [31:0]   instr_o;
   logic [31:0]   pc_o;
   logic [CW-1:0] count_o;
   logic          stale_drop_o;

   modport slave (
      input  flush_i, ic_rsp_valid_i, ic_rsp_data_i, ic_rsp_pc_i, ic_rsp_epoch_i, instr_ready_i,
      output ic_rsp_ready_o, epoch_o, instr_valid_o, instr_o, pc_o, count_o, stale_drop_o
   );

   modport master (
      output flush_i, ic_rsp_valid_i, ic_rsp_data_i, ic_rsp_pc_i, ic_rsp_epoch_i, instr_ready_i,
      input  ic_rsp_ready_o, epoch_o, instr_valid_o, instr_o, pc_o, count_o, stale_drop_o
   );
endinterface

// File: rtl/instr_buffer.sv
// rtl/instr_buffer.sv - epoch-tagged instruction FIFO between fetch and decode
// Responses carrying an old epoch are dropped so a redirect never leaks wrong-path instructions.
module instr_buffer #(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic           clk_i,
   input  logic           rst_i,
   instr_buffer_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [31:0]   instr_mem [DEPTH];
   logic [31:0]   pc_mem    [DEPTH];
   logic          epoch_q;
   logic          stale_q;

   logic          empty;
   logic          full;
   logic          rsp_hs;
   logic          accept;
   logic          stale;
   logic          deq;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

   // Reset gating keeps both handshakes closed while rst_i is high, not just after the edge.
   assign bus.ic_rsp_ready_o = !full && !bus.flush_i && !rst_i;
   assign bus.instr_valid_o  = !empty && !bus.flush_i && !rst_i;

   assign rsp_hs = bus.ic_rsp_valid_i && bus.ic_rsp_ready_o;
   assign accept = rsp_hs && (bus.ic_rsp_epoch_i == epoch_q);
   assign stale  = rsp_hs && (bus.ic_rsp_epoch_i != epoch_q);
   assign deq    = bus.instr_valid_o && bus.instr_ready_i;

   assign bus.count_o      = wr_ptr - rd_ptr;
   assign bus.epoch_o      = epoch_q;
   assign bus.stale_drop_o = stale_q;
   assign bus.instr_o      = empty ? NOP_INSTR : instr_mem[rd_ptr[AW-1:0]];
   assign bus.pc_o         = empty ? 32'h0     : pc_mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         epoch_q <= 1'b0;
         stale_q <= 1'b0;
      end else if (bus.flush_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         epoch_q <= !epoch_q;
         stale_q <= 1'b0;
      end else begin
         stale_q <= stale;
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (deq) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept) begin
         instr_mem[wr_ptr[AW-1:0]] <= bus.ic_rsp_data_i;
         pc_mem[wr_ptr[AW-1:0]]    <= bus.ic_rsp_pc_i;
      end
   end
endmodule

// File: tb/tb_instr_buffer.sv
// tb/tb_instr_buffer.sv - queue-model bench for instr_buffer with directed and random phases
module tb_instr_buffer;
   localparam int DEPTH = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   instr_buffer_if #(.DEPTH(DEPTH)) bus ();

   instr_buffer #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = !clk;

   logic [63:0] mq [$];
   logic        m_epoch;
   logic        m_stale;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic m_ready();
      return (mq.size() < DEPTH) && !bus.flush_i && !rst;
   endfunction

   function automatic logic m_valid();
      return (mq.size() != 0) && !bus.flush_i && !rst;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_epoch = 1'b0;
         m_stale = 1'b0;
      end else if (bus.flush_i) begin
         mq.delete();
         m_epoch = !m_epoch;
         m_stale = 1'b0;
      end else begin
         logic hs;
         logic dq;
         hs = bus.ic_rsp_valid_i && m_ready();
         dq = m_valid() && bus.instr_ready_i;
         m_stale = hs && (bus.ic_rsp_epoch_i != m_epoch);
         if (dq) void'(mq.pop_front());
         if (hs && bus.ic_rsp_epoch_i == m_epoch)
            mq.push_back({bus.ic_rsp_data_i, bus.ic_rsp_pc_i});
      end
   end

   always @(negedge clk) begin
      chk("ready", 64'(bus.ic_rsp_ready_o), 64'(m_ready()));
      chk("valid", 64'(bus.instr_valid_o), 64'(m_valid()));
      chk("count", 64'(bus.count_o), 64'(mq.size()));
      chk("epoch", 64'(bus.epoch_o), 64'(m_epoch));
      chk("stale", 64'(bus.stale_drop_o), 64'(m_stale));
      chk("instr", 64'(bus.instr_o), (mq.size() != 0) ? 64'(mq[0][63:32]) : 64'(NOP));
      chk("pc", 64'(bus.pc_o), (mq.size() != 0) ? 64'(mq[0][31:0]) : 64'h0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.flush_i        = 1'b0;
      bus.ic_rsp_valid_i = 1'b0;
      bus.ic_rsp_data_i  = 32'h0;
      bus.ic_rsp_pc_i    = 32'h0;
      bus.ic_rsp_epoch_i = 1'b0;
      bus.instr_ready_i  = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic drive_rsp(input logic v, input logic [31:0] d, input logic [31:0] p, input logic e);
      bus.ic_rsp_valid_i = v;
      bus.ic_rsp_data_i  = d;
      bus.ic_rsp_pc_i    = p;
      bus.ic_rsp_epoch_i = e;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      idle_inputs();
      #2;
      chk("rst_count", 64'(bus.count_o), 64'h0);
      chk("rst_instr", 64'(bus.instr_o), 64'(NOP));
      chk("rst_ready", 64'(bus.ic_rsp_ready_o), 64'h0);
      do_reset();

      // single push, visible one cycle later
      drive_rsp(1'b1, 32'h0000_0093, 32'h100, 1'b0);
      chk("push1_nobypass", 64'(bus.instr_valid_o), 64'h0);
      tick();
      drive_rsp(1'b0, 32'h0, 32'h0, 1'b0);
      chk("push1_valid", 64'(bus.instr_valid_o), 64'h1);
      chk("push1_instr", 64'(bus.instr_o), 64'h93);
      chk("push1_pc", 64'(bus.pc_o), 64'h100);
      chk("push1_count", 64'(bus.count_o), 64'h1);

      // fill to full, fifth response must wait for a dequeue
      for (int i = 1; i < 4; i++) begin
         drive_rsp(1'b1, 32'h1000 + 32'(i), 32'h100 + 32'(4 * i), 1'b0);
         tick();
      end
      drive_rsp(1'b1, 32'h5555, 32'h200, 1'b0);
      chk("full_count", 64'(bus.count_o), 64'h4);
      chk("full_ready", 64'(bus.ic_rsp_ready_o), 64'h0);
      tick();
      chk("held_count", 64'(bus.count_o), 64'h4);
      bus.instr_ready_i = 1'b1;
      tick();
      bus.instr_ready_i = 1'b0;
      chk("deq_count", 64'(bus.count_o), 64'h3);
      chk("deq_head_pc", 64'(bus.pc_o), 64'h104);
      tick();
      drive_rsp(1'b0, 32'h0, 32'h0, 1'b0);
      chk("fifth_in_count", 64'(bus.count_o), 64'h4);

      // steady streaming across the pointer wrap
      do_reset();
      drive_rsp(1'b1, 32'h2000, 32'h0, 1'b0);
      tick();
      bus.instr_ready_i = 1'b1;
      for (int k = 1; k < 10; k++) begin
         drive_rsp(1'b1, 32'h2000 + 32'(k), 32'(4 * k), 1'b0);
         tick();
         chk("stream_pc", 64'(bus.pc_o), 64'(4 * k));
         chk("stream_count", 64'(bus.count_o), 64'h1);
      end
      drive_rsp(1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      bus.instr_ready_i = 1'b0;
      chk("stream_drained", 64'(bus.count_o), 64'h0);

      // flush with 3 buffered, then stale and fresh responses
      for (int i = 0; i < 3; i++) begin
         drive_rsp(1'b1, 32'h3000 + 32'(i), 32'h300 + 32'(4 * i), 1'b0);
         tick();
      end
      drive_rsp(1'b0, 32'h0, 32'h0, 1'b0);
      chk("pre_flush_count", 64'(bus.count_o), 64'h3);
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      chk("flush_count", 64'(bus.count_o), 64'h0);
      chk("flush_valid", 64'(bus.instr_valid_o), 64'h0);
      chk("flush_epoch", 64'(bus.epoch_o), 64'h1);
      drive_rsp(1'b1, 32'h4000, 32'h400, 1'b0);
      tick();
      chk("stale_pulse", 64'(bus.stale_drop_o), 64'h1);
      chk("stale_count", 64'(bus.count_o), 64'h0);
      drive_rsp(1'b1, 32'h4001, 32'h404, 1'b1);
      tick();
      drive_rsp(1'b0, 32'h0, 32'h0, 1'b0);
      chk("fresh_pulse", 64'(bus.stale_drop_o), 64'h0);
      chk("fresh_count", 64'(bus.count_o), 64'h1);
      chk("fresh_instr", 64'(bus.instr_o), 64'h4001);

      // randomized traffic; the negedge comparator carries the checking
      for (int c = 0; c < 400; c++) begin
         bus.flush_i       = ($urandom_range(0, 19) == 0);
         bus.instr_ready_i = ($urandom_range(0, 2) != 0);
         drive_rsp($urandom_range(0, 3) != 0, $urandom, $urandom,
                   ($urandom_range(0, 9) < 8) ? m_epoch : !m_epoch);
         tick();
      end
      idle_inputs();

      // asynchronous reset between edges with 2 entries buffered
      do_reset();
      drive_rsp(1'b1, 32'h6000, 32'h600, 1'b0);
      tick();
      drive_rsp(1'b1, 32'h6001, 32'h604, 1'b0);
      tick();
      drive_rsp(1'b0, 32'h0, 32'h0, 1'b0);
      chk("ar_pre_count", 64'(bus.count_o), 64'h2);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_valid", 64'(bus.instr_valid_o), 64'h0);
      chk("ar_instr", 64'(bus.instr_o), 64'h13);
      chk("ar_count", 64'(bus.count_o), 64'h0);
      chk("ar_ready", 64'(bus.ic_rsp_ready_o), 64'h0);
      tick();
      rst = 1'b0;
      tick();
      chk("ar_after_count", 64'(bus.count_o), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
